mul_unit: RTL and testbench

- Multiply functional unit in the execute stage; consumes operations that issue routes to the Mult unit (iss_mul_oper).
- Multi-cycle, non-pipelined: 32x32 signed/unsigned multiply producing a 64-bit product in HI/LO and a low-word register writeback.
- Holds the result until the writeback/scoreboard side acknowledges it; back-pressures issue through mul_busy.

---
 rtl/mul_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Multi-cycle, non-pipelined 32x32 signed/unsigned multiplier with held writeback result.
// Optional overflow flag on mul_wb_ov is built only when MUL_OVERFLOW_EN is defined.
module mul_unit #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_mul_oper,
  input  logic [31:0] iss_ex_rega,
  input  logic [31:0] iss_ex_regb,
  input  logic        iss_ex_unsig,
  input  logic [4:0]  iss_ex_regdest,
  input  logic        iss_ex_writereg,
  input  logic        mul_flush,
  input  logic        mul_wb_ack,
  output logic        mul_busy,
  output logic        mul_wb_valid,
  output logic [4:0]  mul_wb_regdest,
  output logic        mul_wb_writereg,
  output logic [31:0] mul_wb_data,
  output logic        mul_wb_ov,
  output logic [31:0] mul_hi,
  output logic [31:0] mul_lo,
  output logic [1:0]  mul_dbg_state
);

  // Handshake: an operation is accepted on an edge where iss_mul_oper=1 and
  // mul_busy=0 (IDLE, or DONE with mul_wb_ack=1); a result is presented while
  // mul_wb_valid=1 and is consumed on the edge where mul_wb_ack=1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CW = 5;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam bit DIRECT = (LATENCY == 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   op_a_q, op_b_q;
  logic          op_unsig_q, op_wr_q;
  logic [4:0]    op_rd_q;
  logic [31:0]   wb_data_q, hi_q, lo_q;
  logic [4:0]    wb_rd_q;
  logic          wb_wr_q;

  logic          accept, complete;
  logic [31:0]   src_a, src_b;
  logic          src_unsig, src_wr;
  logic [4:0]    src_rd;
  logic [63:0]   a_ext, b_ext, product;

  assign accept = iss_mul_oper &&
                  ((state_q == S_IDLE) || ((state_q == S_DONE) && mul_wb_ack));

  // With single-cycle latency the result is formed straight from the issue operands.
  assign src_a     = DIRECT ? iss_ex_rega     : op_a_q;
  assign src_b     = DIRECT ? iss_ex_regb     : op_b_q;
  assign src_unsig = DIRECT ? iss_ex_unsig    : op_unsig_q;
  assign src_rd    = DIRECT ? iss_ex_regdest  : op_rd_q;
  assign src_wr    = DIRECT ? iss_ex_writereg : op_wr_q;

  assign a_ext   = src_unsig ? {32'b0, src_a} : {{32{src_a[31]}}, src_a};
  assign b_ext   = src_unsig ? {32'b0, src_b} : {{32{src_b[31]}}, src_b};
  assign product = a_ext * b_ext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = DIRECT ? S_DONE : S_BUSY;
          cnt_d    = CNT_INIT;
          complete = DIRECT;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (mul_wb_ack) begin
          if (accept) begin
            state_d  = DIRECT ? S_DONE : S_BUSY;
            cnt_d    = CNT_INIT;
            complete = DIRECT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush dominates every transition, including a same-cycle accept or completion.
    if (mul_flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_unsig_q <= 1'b0;
      op_rd_q    <= '0;
      op_wr_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_wr_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && !mul_flush) begin
        op_a_q     <= iss_ex_rega;
        op_b_q     <= iss_ex_regb;
        op_unsig_q <= iss_ex_unsig;
        op_rd_q    <= iss_ex_regdest;
        op_wr_q    <= iss_ex_writereg;
      end
      if (complete) begin
        wb_data_q <= product[31:0];
        wb_rd_q   <= src_rd;
        wb_wr_q   <= src_wr;
        hi_q      <= product[63:32];
        lo_q      <= product[31:0];
      end
    end
  end

`ifdef MUL_OVERFLOW_EN
  logic ov_q, ov_d;

  assign ov_d = src_unsig ? (product[63:32] != 32'b0)
                          : (product[63:32] != {32{product[31]}});

  always_ff @(posedge clock) begin
    if (reset) begin
      ov_q <= 1'b0;
    end else if (complete) begin
      ov_q <= ov_d;
    end
  end

  assign mul_wb_ov = ov_q;
`else
  assign mul_wb_ov = 1'b0;
`endif

  assign mul_busy        = (state_q == S_BUSY) || ((state_q == S_DONE) && !mul_wb_ack);
  assign mul_wb_valid    = (state_q == S_DONE);
  assign mul_wb_regdest  = wb_rd_q;
  assign mul_wb_writereg = wb_wr_q;
  assign mul_wb_data     = wb_data_q;
  assign mul_hi          = hi_q;
  assign mul_lo          = lo_q;
  assign mul_dbg_state   = state_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: driver pushes reference results, a negedge monitor pops and compares.
module tb_mul_unit;

  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iss_mul_oper = 1'b0;
  logic [31:0] iss_ex_rega = '0;
  logic [31:0] iss_ex_regb = '0;
  logic        iss_ex_unsig = 1'b0;
  logic [4:0]  iss_ex_regdest = '0;
  logic        iss_ex_writereg = 1'b0;
  logic        mul_flush = 1'b0;
  logic        mul_wb_ack = 1'b0;
  logic        mul_busy;
  logic        mul_wb_valid;
  logic [4:0]  mul_wb_regdest;
  logic        mul_wb_writereg;
  logic [31:0] mul_wb_data;
  logic        mul_wb_ov;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic [1:0]  dbg_state;

  mul_unit #(.LATENCY(LAT)) dut (
    .clock           (clock),
    .reset           (reset),
    .iss_mul_oper    (iss_mul_oper),
    .iss_ex_rega     (iss_ex_rega),
    .iss_ex_regb     (iss_ex_regb),
    .iss_ex_unsig    (iss_ex_unsig),
    .iss_ex_regdest  (iss_ex_regdest),
    .iss_ex_writereg (iss_ex_writereg),
    .mul_flush       (mul_flush),
    .mul_wb_ack      (mul_wb_ack),
    .mul_busy        (mul_busy),
    .mul_wb_valid    (mul_wb_valid),
    .mul_wb_regdest  (mul_wb_regdest),
    .mul_wb_writereg (mul_wb_writereg),
    .mul_wb_data     (mul_wb_data),
    .mul_wb_ov       (mul_wb_ov),
    .mul_hi          (mul_hi),
    .mul_lo          (mul_lo),
    .mul_dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  rd;
    logic        wr;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          mon_en = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ack = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: exact mathematical product of the two operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic u, input logic [4:0] rd, input logic wr);
    exp_t   e;
    longint sa, sb, sp;
    logic [63:0] p;
    if (u) begin
      p = 64'(a) * 64'(b);
      e.ov = (p > 64'h0000_0000_FFFF_FFFF);
    end else begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      sp = sa * sb;
      p  = sp;
      e.ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    end
`ifndef MUL_OVERFLOW_EN
    e.ov = 1'b0;
`endif
    e.data = p[31:0];
    e.hi   = p[63:32];
    e.lo   = p[31:0];
    e.rd   = rd;
    e.wr   = wr;
    e.acc  = 0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (mon_en) begin
      if (mul_wb_valid) begin
        if (!prev_valid || prev_ack) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got data %h, expected no result (cycle %0d)", mul_wb_data, cyc);
          end else begin
            cur  = exp_q.pop_front();
            m_hi = cur.hi;
            m_lo = cur.lo;
            check("latency", 64'(cyc - cur.acc), 64'(LAT));
            check("wb_data", 64'(mul_wb_data), 64'(cur.data));
            check("wb_regdest", 64'(mul_wb_regdest), 64'(cur.rd));
            check("wb_writereg", 64'(mul_wb_writereg), 64'(cur.wr));
            check("wb_ov", 64'(mul_wb_ov), 64'(cur.ov));
          end
        end else begin
          check("hold_data", 64'(mul_wb_data), 64'(cur.data));
          check("hold_regdest", 64'(mul_wb_regdest), 64'(cur.rd));
        end
      end
      check("hi", 64'(mul_hi), 64'(m_hi));
      check("lo", 64'(mul_lo), 64'(m_lo));
    end
    prev_valid = mul_wb_valid;
    prev_ack   = mul_wb_ack;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", 64'(mul_wb_valid), 64'd0);
    check("rst_busy", 64'(mul_busy), 64'd0);
    check("rst_data", 64'(mul_wb_data), 64'd0);
    check("rst_regdest", 64'(mul_wb_regdest), 64'd0);
    check("rst_writereg", 64'(mul_wb_writereg), 64'd0);
    check("rst_ov", 64'(mul_wb_ov), 64'd0);
    check("rst_hi", 64'(mul_hi), 64'd0);
    check("rst_lo", 64'(mul_lo), 64'd0);
    exp_q.delete();
    m_hi       = '0;
    m_lo       = '0;
    prev_valid = 1'b0;
    prev_ack   = 1'b0;
    mon_en     = 1'b1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                          input logic u, input logic [4:0] rd, input logic wr);
    iss_ex_rega     = a;
    iss_ex_regb     = b;
    iss_ex_unsig    = u;
    iss_ex_regdest  = rd;
    iss_ex_writereg = wr;
    iss_mul_oper    = 1'b1;
  endtask

  // Caller guarantees the unit can accept on the coming edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic u, input logic [4:0] rd, input logic wr);
    exp_t e;
    drive_op(a, b, u, rd, wr);
    step();
    iss_mul_oper = 1'b0;
    e     = model(a, b, u, rd, wr);
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < LAT + 4 && !mul_wb_valid; i++) begin
      check("busy_running", 64'(mul_busy), 64'd1);
      step();
    end
    if (!mul_wb_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL valid_timeout: got valid=0 after %0d cycles, expected valid=1", LAT + 4);
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      check("hold_valid", 64'(mul_wb_valid), 64'd1);
      check("hold_busy", 64'(mul_busy), 64'd1);
      step();
    end
  endtask

  task automatic ack_only();
    mul_wb_ack = 1'b1;
    #1;
    check("ack_busy", 64'(mul_busy), 64'd0);
    step();
    mul_wb_ack = 1'b0;
    check("post_ack_valid", 64'(mul_wb_valid), 64'd0);
    check("post_ack_busy", 64'(mul_busy), 64'd0);
  endtask

  task automatic ack_with_op(input logic [31:0] a, input logic [31:0] b,
                             input logic u, input logic [4:0] rd, input logic wr);
    mul_wb_ack = 1'b1;
    issue(a, b, u, rd, wr);
    mul_wb_ack = 1'b0;
    check("b2b_busy", 64'(mul_busy), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_valid", 64'(mul_wb_valid), 64'd0);
      step();
    end
  endtask

  task automatic flush_test(input int delay);
    issue(32'd5, 32'd5, 1'b0, 5'd9, 1'b1);
    repeat (delay) step();
    mul_flush = 1'b1;
    step();
    mul_flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_busy", 64'(mul_busy), 64'd0);
    idle_cycles(LAT + 2);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] tbl [6];
    tbl[0] = 32'h0000_0000;
    tbl[1] = 32'h0000_0001;
    tbl[2] = 32'hFFFF_FFFF;
    tbl[3] = 32'h8000_0000;
    tbl[4] = 32'h7FFF_FFFF;
    tbl[5] = 32'h0001_0000;
    if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    step();
    do_reset();

    // signed basic: -3 x 7
    issue(32'hFFFF_FFFD, 32'd7, 1'b0, 5'd5, 1'b1);
    wait_valid();
    check("basic_data", 64'(mul_wb_data), 64'hFFFF_FFEB);
    check("basic_hi", 64'(mul_hi), 64'hFFFF_FFFF);
    hold(3);
    ack_with_op(32'd2, 32'd3, 1'b0, 5'd6, 1'b1);
    wait_valid();
    check("b2b_data", 64'(mul_wb_data), 64'd6);
    ack_only();

    // unsigned wide and signed overflow
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd7, 1'b1);
    wait_valid();
    check("uwide_hi", 64'(mul_hi), 64'hFFFF_FFFE);
    check("uwide_lo", 64'(mul_lo), 64'h0000_0001);
    ack_with_op(32'h0001_0000, 32'h0001_0000, 1'b0, 5'd8, 1'b0);
    wait_valid();
    check("sovf_hi", 64'(mul_hi), 64'd1);
    ack_only();

    // flush mid-run, on the completion cycle, and together with an accept
    flush_test(1);
    flush_test(LAT - 1);
    drive_op(32'd9, 32'd9, 1'b0, 5'd1, 1'b1);
    mul_flush = 1'b1;
    step();
    iss_mul_oper = 1'b0;
    mul_flush    = 1'b0;
    check("flush_accept_busy", 64'(mul_busy), 64'd0);
    idle_cycles(LAT + 2);

    // op presented while busy must be dropped
    issue(32'd11, 32'd13, 1'b1, 5'd3, 1'b1);
    drive_op(32'd100, 32'd100, 1'b1, 5'd4, 1'b0);
    step();
    iss_mul_oper = 1'b0;
    wait_valid();
    check("drop_data", 64'(mul_wb_data), 64'd143);
    ack_only();
    idle_cycles(LAT + 2);

    // reset in the middle of an operation
    issue(32'd21, 32'd2, 1'b0, 5'd12, 1'b1);
    step();
    do_reset();
    idle_cycles(LAT + 2);

    // randomized traffic with random ack delay and back-to-back issue
    issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 40; n++) begin
      wait_valid();
      hold($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        ack_with_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        ack_only();
        idle_cycles($urandom_range(0, 2));
        issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
    end
    wait_valid();
    ack_only();
    idle_cycles(3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
